main_job_scheduler: RTL and testbench
=====================================

Name: main_job_scheduler

Overview:
- Two-requester round-robin scheduler in front of the single `main` compute unit.
- Arbitrates operand/mode jobs and drives the unit's x/on/start inputs.
- Tracks the unit's busy flag `b`, returns the `y` result to the granted requester, and aborts hung jobs on timeout.
- Sits between the two client blocks and one `main` instance.

Parameters:
- TIMEOUT, 16: max cycles waited in each of WAIT_BUSY and WAIT_DONE before abort (≥2).
- W, 8: operand/result width (matches `main` x/y).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 job request (level)
- x0  in  W  requester 0 operand
- mode0  in  2  requester 0 regime (1..3; 0 invalid)
- ack0  out  1  1-cycle pulse: job from requester 0 accepted, operands latched
- done0  out  1  1-cycle pulse: requester 0 job finished
- y0  out  W  requester 0 result, valid with done0, held until next done0
- err0  out  1  valid with done0: 1 = rejected or timed out
- req1, x1, mode1, ack1, done1, y1, err1: same as above for requester 1
- dp_x  out  W  to `main` x
- dp_on  out  2  to `main` on
- dp_start  out  1  to `main` start
- dp_y  in  W  from `main` y
- dp_b  in  1  from `main` b (1 while computing)
- busy  out  1  scheduler not in IDLE
- owner  out  1  id of the current or last granted requester

Behaviour:
- Reset: all outputs 0; state IDLE. last_grant=1, so requester 0 wins the first tie. Reset mid-job abandons the job with no done pulse and dp_on=0 in the next cycle.
- States: IDLE, SETUP, FIRE, WAIT_BUSY, WAIT_DONE, RESP, ABORT.
- IDLE:
  - dp_on=0, dp_start=0.
  - If any req is high, pick the requester: if only one requests, it wins; if both, the one ≠ last_grant wins.
  - Latch its x and mode, set owner and last_grant, pulse ack for 1 cycle.
  - If latched mode==0, go to RESP with err=1 and no datapath activity. Otherwise go to SETUP.
- SETUP: dp_x=latched x, dp_on=latched mode, 1 cycle → FIRE.
- FIRE: dp_start=1 for exactly this cycle; dp_x and dp_on held → WAIT_BUSY. Cycle counter cleared.
- WAIT_BUSY:
  - dp_b==1 → WAIT_DONE, counter cleared.
  - Else counter++; counter reaching TIMEOUT → ABORT.
- WAIT_DONE:
  - dp_b==0 → capture dp_y into an internal result register this cycle → RESP.
  - Else counter++; counter reaching TIMEOUT → ABORT.
- ABORT: dp_on=0, dp_start=0 for 1 cycle; err flag set; result register = 0 → RESP.
- RESP:
  - Pulse done<owner>; y<owner>=result, err<owner>=err flag.
  - The non-owner's y/err are unchanged.
  - → IDLE, where dp_on returns to 0.
- dp_x and dp_on hold their values from SETUP through WAIT_DONE; dp_on=0 in IDLE, RESP and ABORT.
- Latency, no contention: ack at cycle 0 (IDLE), dp_start at cycle 2; done = cycle of dp_b fall + 1.
- Request handshake:
  - req is sampled only in IDLE.
  - Requester drops req after ack. If req is still high in IDLE after done, it counts as a new request.
  - x/mode changes after ack are ignored.
- A requester never receives ack while its previous job is in flight.
- Simultaneous: both req high for consecutive jobs alternate 0,1,0,1. One requester alone is granted back-to-back.
- dp_b already high in FIRE is ignored; dp_b is evaluated from WAIT_BUSY onward.

Test Plan:
- Reset then single job: req0=1, x0=5, mode0=1; model `main` raises dp_b 1 cycle after start, drops it 3 cycles later with dp_y=10. Required: ack0 at c0, dp_on=1 at c1, dp_start=1 at c2 only, done0 with y0=10, err0=0, dp_on=0 after RESP.
- Contention: req0 and req1 both held high with different x. Required: grants 0,1,0,1; each done goes to the matching id; y of the other requester unchanged.
- Invalid mode: req1=1, mode1=0. Required: ack1, then done1 with err1=1 the next cycle; dp_start never asserted; dp_on stays 0.
- Timeout: dp_b held 0 after start, TIMEOUT=16. Required: ABORT after 16 WAIT_BUSY cycles, dp_on=0, done with err=1, y=0. Repeat with dp_b stuck at 1 to cover the WAIT_DONE timeout.
- Reset mid-job: assert rst during WAIT_DONE. Required: next cycle all outputs 0, state IDLE, no done pulse; the next req0 job completes normally.
- Operand hold: change x0/mode0 after ack0. Required: dp_x/dp_on keep the latched values until RESP.

Source files
------------

// File: rtl/main_job_scheduler.sv
// Round-robin scheduler for two requesters sharing one `main` compute unit.
// Drives x/on/start, watches busy `b`, routes `y` back, aborts on timeout.
module main_job_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] x0,
  input  logic [1:0]   mode0,
  output logic         ack0,
  output logic         done0,
  output logic [W-1:0] y0,
  output logic         err0,
  input  logic         req1,
  input  logic [W-1:0] x1,
  input  logic [1:0]   mode1,
  output logic         ack1,
  output logic         done1,
  output logic [W-1:0] y1,
  output logic         err1,
  output logic [W-1:0] dp_x,
  output logic [1:0]   dp_on,
  output logic         dp_start,
  input  logic [W-1:0] dp_y,
  input  logic         dp_b,
  output logic         busy,
  output logic         owner
);

  localparam int             CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LP_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  LP_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  LP_CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_FIRE      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5,
    S_ABORT     = 3'd6
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_x;
  logic [1:0]    r_mode;
  logic          r_owner, r_last, r_pend, r_busy;
  logic          r_ack0, r_ack1, r_done0, r_done1, r_err0, r_err1;
  logic [W-1:0]  r_y0, r_y1, r_dp_x;
  logic [1:0]    r_dp_on;
  logic          r_dp_start;

  logic          w_any, w_gnt;
  logic [W-1:0]  w_x;
  logic [1:0]    w_mode;
  logic          w_emit, w_emit_err;
  logic [W-1:0]  w_emit_y;

  // Grant selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    w_any = req0 | req1;
    if (req0 && req1) begin
      w_gnt = ~r_last;
    end else begin
      w_gnt = req1;
    end
    if (w_gnt) begin
      w_x    = x1;
      w_mode = mode1;
    end else begin
      w_x    = x0;
      w_mode = mode0;
    end
  end

  // Response source: a rejected job is answered one cycle after its ack (r_pend).
  always_comb begin
    w_emit     = 1'b0;
    w_emit_y   = {W{1'b0}};
    w_emit_err = 1'b0;
    case (r_state)
      S_WAIT_DONE: begin
        if (!dp_b) begin
          w_emit   = 1'b1;
          w_emit_y = dp_y;
        end else begin
          w_emit   = 1'b0;
        end
      end
      S_ABORT: begin
        w_emit     = 1'b1;
        w_emit_err = 1'b1;
      end
      S_RESP: begin
        w_emit     = r_pend;
        w_emit_err = 1'b1;
      end
      default: w_emit = 1'b0;
    endcase
  end

  // Scheduler FSM; every output is registered on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= LP_CNT_ZERO;
      r_x        <= {W{1'b0}};
      r_mode     <= 2'b00;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_y0       <= {W{1'b0}};
      r_y1       <= {W{1'b0}};
      r_dp_x     <= {W{1'b0}};
      r_dp_on    <= 2'b00;
      r_dp_start <= 1'b0;
    end else begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_dp_start <= 1'b0;
      r_done0    <= w_emit & ~r_owner;
      r_done1    <= w_emit & r_owner;
      if (w_emit && !r_owner) begin
        r_y0   <= w_emit_y;
        r_err0 <= w_emit_err;
      end
      if (w_emit && r_owner) begin
        r_y1   <= w_emit_y;
        r_err1 <= w_emit_err;
      end
      case (r_state)
        S_IDLE: begin
          r_dp_on <= 2'b00;
          if (w_any) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
            r_x     <= w_x;
            r_mode  <= w_mode;
            r_ack0  <= ~w_gnt;
            r_ack1  <= w_gnt;
            r_busy  <= 1'b1;
            if (w_mode == 2'b00) begin
              r_pend  <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_dp_x  <= r_x;
          r_dp_on <= r_mode;
          r_state <= S_FIRE;
        end
        S_FIRE: begin
          r_dp_start <= 1'b1;
          r_cnt      <= LP_CNT_ZERO;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (dp_b) begin
            r_cnt   <= LP_CNT_ZERO;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_dp_on <= 2'b00;
            r_state <= S_ABORT;
          end else begin
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (!dp_b) begin
            r_dp_on <= 2'b00;
            r_state <= S_RESP;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_dp_on <= 2'b00;
            r_state <= S_ABORT;
          end else begin
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end
        S_ABORT: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_pend  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_dp_on <= 2'b00;
          r_pend  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign y0       = r_y0;
  assign y1       = r_y1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign dp_x     = r_dp_x;
  assign dp_on    = r_dp_on;
  assign dp_start = r_dp_start;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule

// File: tb/tb_main_job_scheduler.sv
// Directed bench for main_job_scheduler with a small behavioural `main` unit model.
module tb_main_job_scheduler;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req0, req1;
  logic [W-1:0]  x0, x1;
  logic [1:0]    mode0, mode1;
  logic          ack0, done0, err0, ack1, done1, err1;
  logic [W-1:0]  y0, y1, dp_x;
  logic [W-1:0]  dp_y = 8'h00;
  logic          dp_b = 1'b0;
  logic [1:0]    dp_on;
  logic          dp_start, busy, owner;

  int n_pass  = 0;
  int n_total = 0;
  int m_mode  = 0;   // 0: normal unit, 1: b stuck low, 2: b stuck high
  int m_cnt   = 0;

  main_job_scheduler #(.TIMEOUT(TO), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .mode0(mode0), .ack0(ack0), .done0(done0), .y0(y0), .err0(err0),
    .req1(req1), .x1(x1), .mode1(mode1), .ack1(ack1), .done1(done1), .y1(y1), .err1(err1),
    .dp_x(dp_x), .dp_on(dp_on), .dp_start(dp_start), .dp_y(dp_y), .dp_b(dp_b),
    .busy(busy), .owner(owner)
  );

  // Unit model: b rises the cycle after start, stays high 3 cycles, y = 2*x.
  always @(posedge clk) begin
    if (m_mode == 1) begin
      dp_b <= 1'b0;
    end else if (m_mode == 2) begin
      dp_b <= 1'b1;
    end else if (dp_start) begin
      dp_b  <= 1'b1;
      m_cnt <= 3;
      dp_y  <= {dp_x[W-2:0], 1'b0};
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      m_cnt <= 0;
      dp_b  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // which: 0 any ack, 1 done0, 2 done1, 3 dp_start
  task automatic wait_for(input int which, input string tag, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      case (which)
        0:       hit = ack0 | ack1;
        1:       hit = done0;
        2:       hit = done1;
        default: hit = dp_start;
      endcase
      if (!hit) begin
        tick();
        cyc++;
      end
    end
    chk(tag, {31'b0, hit}, 32'd1);
  endtask

  int       cyc, cnt, gid;
  logic     seen;
  logic [W-1:0] exp_y0, exp_y1;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    x0 = 8'h00; x1 = 8'h00; mode0 = 2'd0; mode1 = 2'd0;
    repeat (3) tick();
    chk("reset_ctl", {23'b0, ack0, ack1, done0, done1, err0, err1, dp_start, busy, owner}, 32'd0);
    chk("reset_data", {6'b0, dp_on, dp_x, y0, y1}, 32'd0);
    rst = 1'b0;
    tick();

    // Single job on requester 0
    req0 = 1'b1; x0 = 8'd5; mode0 = 2'd1;
    tick();
    chk("t1_ack0_c0", {31'b0, ack0}, 32'd1);
    chk("t1_busy_c0", {31'b0, busy}, 32'd1);
    chk("t1_on_c0", {30'b0, dp_on}, 32'd0);
    req0 = 1'b0;
    tick();
    chk("t1_on_c1", {30'b0, dp_on}, 32'd1);
    chk("t1_x_c1", {24'b0, dp_x}, 32'd5);
    chk("t1_start_c1", {31'b0, dp_start}, 32'd0);
    tick();
    chk("t1_start_c2", {31'b0, dp_start}, 32'd1);
    tick();
    chk("t1_start_c3", {31'b0, dp_start}, 32'd0);
    wait_for(1, "t1_done_wait", cyc);
    chk("t1_done_cycle", cyc + 3, 32'd7);
    chk("t1_y0", {24'b0, y0}, 32'd10);
    chk("t1_err0", {31'b0, err0}, 32'd0);
    chk("t1_on_resp", {30'b0, dp_on}, 32'd0);
    chk("t1_y1_kept", {24'b0, y1}, 32'd0);
    tick();
    chk("t1_idle", {29'b0, done0, busy, dp_on != 2'd0}, 32'd0);

    // Invalid mode on requester 1
    req1 = 1'b1; x1 = 8'd9; mode1 = 2'd0;
    tick();
    chk("t2_ack1", {30'b0, ack1, ack0}, 32'd2);
    chk("t2_owner", {31'b0, owner}, 32'd1);
    req1 = 1'b0;
    tick();
    chk("t2_done1", {30'b0, done1, err1}, 32'd3);
    chk("t2_y1", {24'b0, y1}, 32'd0);
    chk("t2_no_dp", {29'b0, dp_start, dp_on}, 32'd0);
    chk("t2_y0_kept", {24'b0, y0}, 32'd10);
    chk("t2_done0", {31'b0, done0}, 32'd0);
    tick();

    // Contention: both held, grants alternate starting with 0
    exp_y0 = 8'd10; exp_y1 = 8'd0;
    req0 = 1'b1; x0 = 8'd3; mode0 = 2'd2;
    req1 = 1'b1; x1 = 8'd7; mode1 = 2'd3;
    for (int j = 0; j < 4; j++) begin
      gid = j % 2;
      wait_for(0, "t3_ack_wait", cyc);
      chk("t3_grant", {31'b0, ack1}, gid);
      chk("t3_ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
      chk("t3_owner", {31'b0, owner}, gid);
      wait_for(gid == 0 ? 1 : 2, "t3_done_wait", cyc);
      if (gid == 0) exp_y0 = 8'd6; else exp_y1 = 8'd14;
      chk("t3_other_done", {31'b0, gid == 0 ? done1 : done0}, 32'd0);
      chk("t3_y0", {24'b0, y0}, {24'b0, exp_y0});
      chk("t3_y1", {24'b0, y1}, {24'b0, exp_y1});
      chk("t3_err", {31'b0, gid == 0 ? err0 : err1}, 32'd0);
      if (j == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
    end
    tick();

    // Timeout in WAIT_BUSY
    m_mode = 1;
    req0 = 1'b1; x0 = 8'h21; mode0 = 2'd1;
    tick();
    chk("t4_ack0", {31'b0, ack0}, 32'd1);
    req0 = 1'b0;
    wait_for(3, "t4_start_wait", cyc);
    cnt = 0;
    while (dp_on != 2'd0 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("t4_busy_cycles", cnt, TO);
    chk("t4_abort_nodone", {31'b0, done0}, 32'd0);
    tick();
    chk("t4_done0_err", {30'b0, done0, err0}, 32'd3);
    chk("t4_y0", {24'b0, y0}, 32'd0);
    chk("t4_y1_kept", {24'b0, y1}, 32'd14);
    tick();

    // Timeout in WAIT_DONE (b stuck high)
    m_mode = 2;
    tick();
    req1 = 1'b1; x1 = 8'h44; mode1 = 2'd3;
    tick();
    chk("t5_ack1", {31'b0, ack1}, 32'd1);
    req1 = 1'b0;
    wait_for(3, "t5_start_wait", cyc);
    cnt = 0;
    while (dp_on != 2'd0 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("t5_on_cycles", cnt, TO + 1);
    chk("t5_abort_nodone", {31'b0, done1}, 32'd0);
    tick();
    chk("t5_done1_err", {30'b0, done1, err1}, 32'd3);
    chk("t5_y1", {24'b0, y1}, 32'd0);
    tick();

    // Reset in WAIT_DONE
    req0 = 1'b1; x0 = 8'h55; mode0 = 2'd2;
    tick();
    chk("t6_ack0", {31'b0, ack0}, 32'd1);
    req0 = 1'b0;
    repeat (5) tick();
    chk("t6_on_wait", {30'b0, dp_on}, 32'd2);
    rst = 1'b1;
    tick();
    chk("t6_rst_ctl", {23'b0, ack0, ack1, done0, done1, err0, err1, dp_start, busy, owner}, 32'd0);
    chk("t6_rst_data", {6'b0, dp_on, dp_x, y0, y1}, 32'd0);
    rst = 1'b0;
    m_mode = 0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | done0 | done1 | busy;
      tick();
    end
    chk("t6_quiet", {31'b0, seen}, 32'd0);

    // Job after reset, with operands changed after ack
    req0 = 1'b1; x0 = 8'h30; mode0 = 2'd1;
    tick();
    chk("t7_ack0", {31'b0, ack0}, 32'd1);
    req0 = 1'b0; x0 = 8'hFF; mode0 = 2'd3;
    tick();
    chk("t7_hold_c1", {22'b0, dp_on, dp_x}, {22'b0, 2'd1, 8'h30});
    tick();
    chk("t7_start", {31'b0, dp_start}, 32'd1);
    repeat (4) tick();
    chk("t7_hold_c6", {22'b0, dp_on, dp_x}, {22'b0, 2'd1, 8'h30});
    wait_for(1, "t7_done_wait", cyc);
    chk("t7_done_cycle", cyc + 6, 32'd7);
    chk("t7_y0", {24'b0, y0}, 32'h60);
    chk("t7_err0", {31'b0, err0}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
